// File: rtl/qsys_basic_sysid_checker.sv
`default_nettype none
// ============================================================================
// qsys_basic_sysid_checker : Avalon-MM read master that fetches the sysid ID
// and timestamp words and compares them against build-time values.
// Revision 1.0
// ============================================================================
module qsys_basic_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h1234ABCD,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1377489413,
    parameter int unsigned TIMEOUT_CYCLES     = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_ID  = 3'd1,
        WAIT_ID = 3'd2,
        REQ_TS  = 3'd3,
        WAIT_TS = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic        at_limit;

    assign at_limit    = (cnt == LIMIT);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign avm_read    = (state == REQ_ID) || (state == REQ_TS);
    assign avm_address = (state == REQ_TS) || (state == WAIT_TS);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= REQ_ID;
                        cnt      <= '0;
                        id_ok    <= 1'b0;
                        ts_ok    <= 1'b0;
                        timeout  <= 1'b0;
                        id_value <= '0;
                        ts_value <= '0;
                    end
                end
                // An accepted request is not a completed transaction, so the
                // limit still wins in the request phase.
                REQ_ID, REQ_TS: begin
                    cnt <= cnt + 16'd1;
                    if (at_limit) begin
                        timeout <= 1'b1;
                        state   <= DONE;
                    end else if (!avm_waitrequest) begin
                        state <= (state == REQ_ID) ? WAIT_ID : WAIT_TS;
                    end
                end
                WAIT_ID: begin
                    cnt <= cnt + 16'd1;
                    if (avm_readdatavalid) begin
                        id_value <= avm_readdata;
                        id_ok    <= (avm_readdata == EXPECTED_ID);
                        cnt      <= '0;
                        state    <= REQ_TS;
                    end else if (at_limit) begin
                        timeout <= 1'b1;
                        state   <= DONE;
                    end
                end
                WAIT_TS: begin
                    cnt <= cnt + 16'd1;
                    if (avm_readdatavalid) begin
                        ts_value <= avm_readdata;
                        ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
                        state    <= DONE;
                    end else if (at_limit) begin
                        timeout <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
